param_update_sched: RTL



---
 rtl/param_update_sched.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/param_update_sched.sv
// param_update_sched: sequential SGD parameter update, x_new = x - (dx >>> lr).
// Walks the flat parameter memory (W1, b1, W2, b2, W3, b3). Each element is
// read, updated through one shared shifter/subtractor, and written back in
// place, taking three cycles per element.
module param_update_sched #(
    parameter int DATA_W = 16,
    parameter int L1     = 4,
    parameter int L2     = 8,
    parameter int L3     = 8,
    parameter int L4     = 2,
    parameter int ADDR_W = 10   // 2**ADDR_W must cover every parameter element
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        learning_rate,
    output logic              busy,
    output logic              done,
    output logic [2:0]        tensor_id,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] p_rd_data,
    input  logic [DATA_W-1:0] g_rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    // Cumulative end offsets of each tensor in the flat memory.
    localparam int END_W1 = L2 * L1;
    localparam int END_B1 = END_W1 + L2;
    localparam int END_W2 = END_B1 + L3 * L2;
    localparam int END_B2 = END_W2 + L3;
    localparam int END_W3 = END_B2 + L4 * L3;
    localparam int TOTAL  = END_W3 + L4;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CALC,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [4:0]        shift_q, shift_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        tensor_q, tensor_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    // Map a flat element index to the tensor it belongs to.
    function automatic logic [2:0] tensor_of(input logic [ADDR_W-1:0] a);
        int ai;
        ai = int'(a);
        if      (ai < END_W1) return 3'd0;
        else if (ai < END_B1) return 3'd1;
        else if (ai < END_W2) return 3'd2;
        else if (ai < END_B2) return 3'd3;
        else if (ai < END_W3) return 3'd4;
        else                  return 3'd5;
    endfunction

    // One SGD step: arithmetic shift with sign fill, saturating to 0/-1 once
    // the shift reaches the word width, then a wrapping subtraction.
    function automatic logic [DATA_W-1:0] sgd_step(input logic [DATA_W-1:0] p,
                                                   input logic [DATA_W-1:0] g,
                                                   input logic [4:0]        sh);
        logic [DATA_W-1:0] step;
        if (int'(sh) >= DATA_W) step = {DATA_W{g[DATA_W-1]}};
        else                    step = $signed(g) >>> sh;
        return p - step;
    endfunction

    // Next-state and registered-output decode for the walk FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        tensor_d  = tensor_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d   = learning_rate;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    tensor_d  = 3'd0;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                // Memory data arrives during CALC.
                state_d = S_CALC;
            end
            S_CALC: begin
                wr_data_d = sgd_step(p_rd_data, g_rd_data, shift_q);
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                state_d   = S_WR;
            end
            S_WR: begin
                if (idx_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d     = idx_q + ADDR_W'(1);
                    rd_en_d   = 1'b1;
                    rd_addr_d = idx_q + ADDR_W'(1);
                    tensor_d  = tensor_of(idx_q + ADDR_W'(1));
                    state_d   = S_RD;
                end
            end
            S_DONE: begin
                // A start arriving here is deliberately dropped.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset returns everything to idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tensor_q  <= 3'd0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tensor_q  <= tensor_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign tensor_id = tensor_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
